// File: rtl/counter_pkg.sv
// Shared constants and small types for the parametrised up/down counter
// family: direction and mode encodings, the width bound and the per-edge
// operation selected by the priority decoder.
package counter_pkg;

   // Direction encoding on up_down
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Boundary behaviour encoding on saturate
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Upper bound on the WIDTH parameter
   localparam int unsigned MAX_WIDTH = 32;
   localparam int unsigned MIN_WIDTH = 2;

   // Operation chosen for one clock edge, in priority order
   // clear > load > enable > hold.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_CLEAR = 2'd1,
      OP_LOAD  = 2'd2,
      OP_STEP  = 2'd3
   } counter_op_e;

   // Resolve the control inputs of one edge into a single operation.
   function automatic counter_op_e decode_op(input logic clear,
                                             input logic load,
                                             input logic enable);
      counter_op_e op;
      if (clear)       op = OP_CLEAR;
      else if (load)   op = OP_LOAD;
      else if (enable) op = OP_STEP;
      else             op = OP_HOLD;
      return op;
   endfunction

endpackage : counter_pkg

// File: rtl/sticky_flag.sv
// Set-dominant sticky flag: once set it holds until cleared, and a set in
// the same cycle as a clear leaves it set.
module sticky_flag (
   input  logic clk,
   input  logic reset_n,
   input  logic set,
   input  logic clear,
   output logic q
);

   // Latch events; set beats clear so a same-cycle event is never lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= 1'b0;
      end else if (set) begin
         q <= 1'b1;
      end else if (clear) begin
         q <= 1'b0;
      end
   end

endmodule : sticky_flag

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with a programmable limit (count range
// 0..limit), synchronous clear/load, wrap-or-saturate boundary handling,
// one-cycle overflow/underflow pulses and sticky copies of both.
// All outputs are registered; there is no input-to-output combinational path.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             up_down,
   input  logic             saturate,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             flag_clear,
   output logic [WIDTH-1:0] counter_out,
   output logic             overflow_out,
   output logic             underflow_out,
   output logic             overflow_sticky,
   output logic             underflow_sticky,
   output logic             at_limit
);

   // Reject out-of-range widths at elaboration time.
   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("param_updown_counter: WIDTH must be in 2..32");
   end

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   counter_op_e      op;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] cnt_dec;
   logic [WIDTH-1:0] load_clamped;
   logic             ovf_evt;
   logic             unf_evt;
   logic             at_limit_nxt;
   logic             sticky_clr;

   // Next-state computation: priority decode, boundary detection and the
   // new count, all from the current registered count and sampled inputs.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      op           = decode_op(clear, load, enable);
      cnt_nxt      = counter_out;
      cnt_dec      = counter_out - ONE;
      load_clamped = (load_value > limit) ? limit : load_value;
      ovf_evt      = 1'b0;
      unf_evt      = 1'b0;

      unique case (op)
         OP_CLEAR: cnt_nxt = ZERO;
         OP_LOAD:  cnt_nxt = load_clamped;
         OP_STEP: begin
            if (up_down == DIR_UP) begin
               // Compare before incrementing: a count at or above the
               // limit is a boundary, so all-ones never relies on carry-out.
               if (counter_out < limit) begin
                  cnt_nxt = counter_out + ONE;
               end else begin
                  ovf_evt = 1'b1;
                  cnt_nxt = (saturate == MODE_SAT) ? limit : ZERO;
               end
            end else begin
               if (counter_out != ZERO) begin
                  // A count left above a lowered limit is pulled back in.
                  cnt_nxt = (cnt_dec > limit) ? limit : cnt_dec;
               end else begin
                  unf_evt = 1'b1;
                  cnt_nxt = (saturate == MODE_SAT) ? ZERO : limit;
               end
            end
         end
         default: cnt_nxt = counter_out;
      endcase

      at_limit_nxt = (cnt_nxt >= limit);
   end

   // Register the count, the boundary pulses and the limit indication.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         counter_out   <= ZERO;
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
         at_limit      <= 1'b0;
      end else begin
         counter_out   <= cnt_nxt;
         overflow_out  <= ovf_evt;
         underflow_out <= unf_evt;
         at_limit      <= at_limit_nxt;
      end
   end

   // A synchronous clear never coincides with an event (clear has top
   // priority), so folding it into the sticky clear zeroes the flags.
   assign sticky_clr = clear | flag_clear;

   sticky_flag u_overflow_sticky (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (ovf_evt),
      .clear   (sticky_clr),
      .q       (overflow_sticky)
   );

   sticky_flag u_underflow_sticky (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (unf_evt),
      .clear   (sticky_clr),
      .q       (underflow_sticky)
   );

endmodule : param_updown_counter
